// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard of in-flight writes. Gates decode issue with a
// combinational stall and exports the pending-write vector. Fixed-latency
// ops count down per register; one variable-latency op completes on dhit.
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int REGW   = 5,
    parameter int NSRC   = 2,
    parameter int MAXLAT = 4,
    parameter int CNTW   = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 issue_valid,
    input  logic [NSRC*REGW-1:0] issue_rsel,
    input  logic [NSRC-1:0]      issue_ruse,
    input  logic                 issue_wen,
    input  logic [REGW-1:0]      issue_wsel,
    input  logic [CNTW-1:0]      issue_lat,
    input  logic                 flush,
    input  logic                 dhit,
    output logic                 stall,
    output logic                 issue_fire,
    output logic [NREG-1:0]      busy,
    output logic                 var_busy,
    output logic [REGW:0]        pend_count
);

    localparam logic [CNTW-1:0] MAXLAT_C = CNTW'(MAXLAT);
    localparam logic [CNTW-1:0] ONE_C    = CNTW'(1);

    // A nonzero counter marks a fixed-latency entry; variable entries keep cnt at 0.
    logic [NREG-1:0]            pend_q, pend_d;
    logic [NREG-1:0][CNTW-1:0]  cnt_q, cnt_d;
    logic                       var_busy_q, var_busy_d;
    logic [REGW-1:0]            var_reg_q, var_reg_d;
    logic [REGW:0]              pend_count_q, pend_count_d;

    logic [NREG-1:0]            comp;
    logic                       raw_haz, waw_haz, str_haz;
    logic                       wr_valid;

    assign busy       = pend_q;
    assign var_busy   = var_busy_q;
    assign pend_count = pend_count_q;
    assign wr_valid   = issue_wen && (issue_wsel != '0);

    // Registers whose pending write lands at the coming edge.
    always_comb begin
        comp = '0;
        for (int r = 0; r < NREG; r++) begin
            comp[r] = (pend_q[r] && (cnt_q[r] == ONE_C)) ||
                      (var_busy_q && (var_reg_q == REGW'(r)) && dhit);
        end
    end

    // Hazard detection; a completing register never stalls because its value is forwarded.
    always_comb begin
        raw_haz = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (issue_ruse[i] && pend_q[issue_rsel[i*REGW +: REGW]] &&
                !comp[issue_rsel[i*REGW +: REGW]]) begin
                raw_haz = 1'b1;
            end
        end
        waw_haz    = wr_valid && pend_q[issue_wsel] && !comp[issue_wsel];
        str_haz    = (issue_lat == '0) && var_busy_q && !dhit;
        stall      = issue_valid && (raw_haz || waw_haz || str_haz);
        issue_fire = issue_valid && !stall && !flush;
    end

    // Next scoreboard state: countdown, completions, then issue (issue wins).
    always_comb begin
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        var_busy_d   = var_busy_q;
        var_reg_d    = var_reg_q;
        pend_count_d = '0;

        for (int r = 0; r < NREG; r++) begin
            if (pend_q[r] && (cnt_q[r] > ONE_C)) begin
                cnt_d[r] = cnt_q[r] - ONE_C;
            end else if (pend_q[r] && (cnt_q[r] == ONE_C)) begin
                pend_d[r] = 1'b0;
                cnt_d[r]  = '0;
            end
        end

        if (dhit && var_busy_q) begin
            pend_d[var_reg_q] = 1'b0;
            var_busy_d        = 1'b0;
        end

        if (issue_fire && wr_valid) begin
            pend_d[issue_wsel] = 1'b1;
            if (issue_lat != '0) begin
                cnt_d[issue_wsel] = (issue_lat > MAXLAT_C) ? MAXLAT_C : issue_lat;
            end else begin
                cnt_d[issue_wsel] = '0;
                var_busy_d        = 1'b1;
                var_reg_d         = issue_wsel;
            end
        end

        for (int r = 0; r < NREG; r++) begin
            pend_count_d = pend_count_d + (REGW+1)'(pend_d[r]);
        end
    end

    // State registers with synchronous reset overriding any in-flight op.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q       <= '0;
            cnt_q        <= '0;
            var_busy_q   <= 1'b0;
            var_reg_q    <= '0;
            pend_count_q <= '0;
        end else begin
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            var_busy_q   <= var_busy_d;
            var_reg_q    <= var_reg_d;
            pend_count_q <= pend_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Expected values are queued as each
// cycle's stimulus is driven and popped/compared at the following negedge.
module tb_hazard_scoreboard;

    logic        CLK = 1'b0;
    logic        RST;
    logic        issue_valid;
    logic [9:0]  issue_rsel;
    logic [1:0]  issue_ruse;
    logic        issue_wen;
    logic [4:0]  issue_wsel;
    logic [2:0]  issue_lat;
    logic        flush;
    logic        dhit;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy;
    logic        var_busy;
    logic [5:0]  pend_count;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } chk_t;

    chk_t q[$];
    int   passed = 0;
    int   total  = 0;

    hazard_scoreboard dut (
        .CLK        (CLK),
        .RST        (RST),
        .issue_valid(issue_valid),
        .issue_rsel (issue_rsel),
        .issue_ruse (issue_ruse),
        .issue_wen  (issue_wen),
        .issue_wsel (issue_wsel),
        .issue_lat  (issue_lat),
        .flush      (flush),
        .dhit       (dhit),
        .stall      (stall),
        .issue_fire (issue_fire),
        .busy       (busy),
        .var_busy   (var_busy),
        .pend_count (pend_count)
    );

    always #5 CLK = ~CLK;

    task automatic drv(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] use_, input logic wen, input logic [4:0] ws,
                       input logic [2:0] lat, input logic fl, input logic dh);
        issue_valid = v;
        issue_rsel  = {r1, r0};
        issue_ruse  = use_;
        issue_wen   = wen;
        issue_wsel  = ws;
        issue_lat   = lat;
        flush       = fl;
        dhit        = dh;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 3'd1, 1'b0, 1'b0);
    endtask

    task automatic exp_io(input string tag, input logic s, input logic f);
        q.push_back('{tag: {tag, ".stall"}, kind: 0, val: 32'(s)});
        q.push_back('{tag: {tag, ".fire"},  kind: 1, val: 32'(f)});
    endtask

    task automatic exp_st(input string tag, input logic [31:0] b, input logic vb,
                          input logic [5:0] pc);
        q.push_back('{tag: {tag, ".busy"},     kind: 2, val: b});
        q.push_back('{tag: {tag, ".var_busy"}, kind: 3, val: 32'(vb)});
        q.push_back('{tag: {tag, ".pcount"},   kind: 4, val: 32'(pc)});
    endtask

    // Sample at negedge, compare everything queued for this cycle, then advance.
    task automatic cyc();
        chk_t        e;
        logic [31:0] act;
        @(negedge CLK);
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                0:       act = 32'(stall);
                1:       act = 32'(issue_fire);
                2:       act = busy;
                3:       act = 32'(var_busy);
                default: act = 32'(pend_count);
            endcase
            total++;
            assert (act === e.val) passed++;
            else $error("FAIL %s actual=%0h expected=%0h", e.tag, act, e.val);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;

        // Reset state
        exp_io("rst", 0, 0); exp_st("rst", 32'h0, 0, 0); cyc();

        // Basic lat=1 write to r5
        drv(1, 5'd3, 5'd4, 2'b11, 1, 5'd5, 3'd1, 0, 0);
        exp_io("t1_iss", 0, 1); exp_st("t1_iss", 32'h0, 0, 0); cyc();
        idle(); exp_io("t1_p", 0, 0); exp_st("t1_p", 32'h20, 0, 1); cyc();
        idle(); exp_st("t1_clr", 32'h0, 0, 0); cyc();

        // Completing bypass, same-register reissue, WAW stall then release
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd5, 3'd1, 0, 0);
        exp_io("t2_a", 0, 1); cyc();
        drv(1, 5'd5, 5'd0, 2'b01, 1, 5'd5, 3'd2, 0, 0);
        exp_io("t2_byp", 0, 1); exp_st("t2_byp", 32'h20, 0, 1); cyc();
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd5, 3'd1, 0, 0);
        exp_io("t2_waw", 1, 0); exp_st("t2_waw", 32'h20, 0, 1); cyc();
        exp_io("t2_wawc", 0, 1); exp_st("t2_wawc", 32'h20, 0, 1); cyc();
        idle(); exp_st("t2_e", 32'h20, 0, 1); cyc();
        idle(); exp_st("t2_f", 32'h0, 0, 0); cyc();

        // lat=3 RAW: stall two cycles, accept on the third
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd7, 3'd3, 0, 0);
        exp_io("t3_iss", 0, 1); cyc();
        drv(1, 5'd7, 5'd0, 2'b01, 0, 5'd0, 3'd1, 0, 0);
        exp_io("t3_c1", 1, 0); exp_st("t3_c1", 32'h80, 0, 1); cyc();
        exp_io("t3_c2", 1, 0); exp_st("t3_c2", 32'h80, 0, 1); cyc();
        exp_io("t3_c3", 0, 1); exp_st("t3_c3", 32'h80, 0, 1); cyc();
        idle(); exp_st("t3_end", 32'h0, 0, 0); cyc();

        // Variable-latency load, RAW and structural stalls, dhit release
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd9, 3'd0, 0, 0);
        exp_io("t4_ld", 0, 1); cyc();
        drv(1, 5'd9, 5'd0, 2'b01, 0, 5'd0, 3'd1, 0, 0);
        exp_io("t4_raw", 1, 0); exp_st("t4_raw", 32'h200, 1, 1); cyc();
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd10, 3'd0, 0, 0);
        exp_io("t4_str", 1, 0); cyc();
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd10, 3'd0, 0, 1);
        exp_io("t4_hit", 0, 1); exp_st("t4_hit", 32'h200, 1, 1); cyc();
        drv(1, 5'd10, 5'd0, 2'b01, 0, 5'd0, 3'd1, 0, 0);
        exp_io("t4_raw2", 1, 0); exp_st("t4_ld2", 32'h400, 1, 1); cyc();
        drv(1, 5'd10, 5'd0, 2'b01, 0, 5'd0, 3'd1, 0, 1);
        exp_io("t4_hit2", 0, 1); cyc();
        drv(0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 3'd1, 0, 1);
        exp_io("t4_idle", 0, 0); exp_st("t4_done", 32'h0, 0, 0); cyc();
        idle(); exp_st("t4_stray", 32'h0, 0, 0); cyc();

        // Latency clamp: lat=6 behaves as 4
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd11, 3'd6, 0, 0);
        exp_io("t5_iss", 0, 1); cyc();
        idle();
        exp_st("t5_c1", 32'h800, 0, 1); cyc();
        exp_st("t5_c2", 32'h800, 0, 1); cyc();
        exp_st("t5_c3", 32'h800, 0, 1); cyc();
        exp_st("t5_c4", 32'h800, 0, 1); cyc();
        exp_st("t5_c5", 32'h0, 0, 0); cyc();

        // Register 0 destination and source
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd0, 3'd2, 0, 0);
        exp_io("t5_w0", 0, 1); cyc();
        drv(1, 5'd0, 5'd0, 2'b11, 0, 5'd0, 3'd1, 0, 0);
        exp_io("t5_r0", 0, 1); exp_st("t5_r0", 32'h0, 0, 0); cyc();

        // Flush blocks acceptance only
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd12, 3'd2, 1, 0);
        exp_io("t6_fl", 0, 0); cyc();
        idle(); exp_st("t6_fl", 32'h0, 0, 0); cyc();

        // Reset with a fixed op and a load in flight
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd2, 3'd4, 0, 0);
        exp_io("t7_a", 0, 1); cyc();
        drv(1, 5'd0, 5'd0, 2'b00, 1, 5'd3, 3'd0, 0, 0);
        exp_io("t7_b", 0, 1); cyc();
        idle(); RST = 1'b1;
        exp_st("t7_pre", 32'h0000000C, 1, 2); cyc();
        RST = 1'b0;
        exp_st("t7_rst", 32'h0, 0, 0); cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
